jc_slot_arbiter: RTL and testbench

//  Time-slot arbiter that shares one downstream resource among NREQ requesters.
//  An internal Johnson counter supplies 2*WIDTH phases, and each phase p is owned by requester p % NREQ.
//  The block polls one phase owner per cycle, grants the resource until release or timeout, and inserts a guard cycle between grants.
//  It sits between the requester ports and the shared resource mux/enable.

---
 rtl/jc_arb_pkg.sv | 22 ++
 rtl/jc_core.sv | 53 +++++
 rtl/jc_slot_arbiter.sv | 108 ++++++++++
 tb/tb_jc_slot_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jc_arb_pkg.sv
// Shared definitions for the Johnson-counter slot arbiter: FSM encodings and a
// width helper that never returns zero, so single-requester builds still get a 1-bit index.
package jc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        GUARD = 2'd2
    } arb_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/jc_core.sv
// Johnson phase generator: WIDTH-stage twisted ring with advance enable,
// recovery from illegal patterns, and decode of the current phase index.
module jc_core
    import jc_arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PW    = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             adv,
    output logic [WIDTH-1:0] jc,
    output logic [PW-1:0]    phase
);

    logic legal;
    int   ones_cnt;

    // Legal patterns are a run of ones anchored at bit 0 (rising half)
    // or a run of ones anchored at the MSB (falling half).
    function automatic logic [WIDTH-1:0] jc_pattern(input int k);
        logic [WIDTH-1:0] ones;
        ones = '1;
        if (k <= WIDTH) begin
            return ones >> (WIDTH - k);
        end
        return ones << (k - WIDTH);
    endfunction

    always_comb begin
        legal = 1'b0;
        for (int k = 0; k < 2*WIDTH; k++) begin
            if (jc == jc_pattern(k)) begin
                legal = 1'b1;
            end
        end
        ones_cnt = $countones(jc);
        phase    = '0;
        if (legal) begin
            phase = jc[WIDTH-1] ? PW'(2*WIDTH - ones_cnt) : PW'(ones_cnt);
        end
    end

    // A corrupted ring is not stepped; it is reloaded to the all-zero phase.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            jc <= '0;
        end else if (adv) begin
            jc <= legal ? {jc[WIDTH-2:0], ~jc[WIDTH-1]} : '0;
        end
    end

endmodule

// File: rtl/jc_slot_arbiter.sv
// Time-slot arbiter: each Johnson phase polls one requester, grants until
// release or SLOT_MAX cycles, then spends one guard cycle before polling again.
module jc_slot_arbiter
    import jc_arb_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int NREQ     = 4,
    parameter int SLOT_MAX = 8
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           en,
    input  logic [NREQ-1:0]                req,
    input  logic [NREQ-1:0]                rel,
    output logic [NREQ-1:0]                gnt,
    output logic [clog2(NREQ)-1:0]         gnt_id,
    output logic                           busy,
    output logic                           timeout,
    output logic [WIDTH-1:0]               jc_state,
    output logic [clog2(2*WIDTH)-1:0]      phase
);

    localparam int IDW = clog2(NREQ);
    localparam int PW  = clog2(2*WIDTH);
    localparam int CW  = clog2(SLOT_MAX);

    if (2*WIDTH < NREQ) begin : g_bad_phase_count
        $error("jc_slot_arbiter: 2*WIDTH must be >= NREQ");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("jc_slot_arbiter: WIDTH must be >= 2");
    end
    if (SLOT_MAX < 1) begin : g_bad_slot_max
        $error("jc_slot_arbiter: SLOT_MAX must be >= 1");
    end

    arb_state_t      state;
    logic [CW-1:0]   slot_cnt;
    logic [IDW-1:0]  owner;
    logic            adv;
    logic            grantee_done;

    assign owner = IDW'(int'(phase) % NREQ);

    // The ring only moves while polling an idle owner, or once per guard cycle.
    assign adv = (state == GUARD) || ((state == IDLE) && en && !req[owner]);

    assign grantee_done = rel[gnt_id] || !req[gnt_id];

    jc_core #(
        .WIDTH (WIDTH),
        .PW    (PW)
    ) u_core (
        .clk   (clk),
        .rstn  (rstn),
        .adv   (adv),
        .jc    (jc_state),
        .phase (phase)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            slot_cnt <= '0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en && req[owner]) begin
                        state    <= BUSY;
                        gnt      <= NREQ'(1) << owner;
                        gnt_id   <= owner;
                        busy     <= 1'b1;
                        slot_cnt <= '0;
                    end
                end
                BUSY: begin
                    // A voluntary release takes priority over the forced one.
                    if (grantee_done) begin
                        state <= GUARD;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end else if (slot_cnt == CW'(SLOT_MAX - 1)) begin
                        state   <= GUARD;
                        gnt     <= '0;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                    end
                end
                GUARD: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jc_slot_arbiter.sv
// Bench for jc_slot_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a phase/grantee model, with literal pins on key cycles.
module tb_jc_slot_arbiter;

    localparam int WIDTH    = 4;
    localparam int NREQ     = 4;
    localparam int SLOT_MAX = 8;
    localparam int PHASES   = 2*WIDTH;
    localparam logic [3:0] JC_SEQ [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                                          4'b1111, 4'b1110, 4'b1100, 4'b1000};

    typedef struct {
        int phase;
        int gr;
        int held;
        bit guard;
        bit to;
    } model_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;
    logic [3:0] jc_state;
    logic [2:0] phase;

    logic       inj = 1'b0;
    logic       cmp_on = 1'b0;
    logic       lit_valid = 1'b0;
    logic [3:0] lit_gnt, lit_jc;
    int         lit_phase;
    logic       lit_busy, lit_to;
    logic [3:0] rnd_req;

    int assertions = 0;
    int failures = 0;

    model_t m = '{phase: 0, gr: -1, held: 0, guard: 1'b0, to: 1'b0};

    jc_slot_arbiter #(
        .WIDTH    (WIDTH),
        .NREQ     (NREQ),
        .SLOT_MAX (SLOT_MAX)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .req      (req),
        .rel      (rel),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .busy     (busy),
        .timeout  (timeout),
        .jc_state (jc_state),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    // One clock of the arbiter's rules: poll owner of the phase, hold up to
    // SLOT_MAX cycles, then one guard cycle that steps to the next phase.
    function automatic model_t modelStep(model_t s, logic e, logic [3:0] r, logic [3:0] l, logic inject);
        model_t n;
        n = s;
        n.to = 1'b0;
        if (s.guard) begin
            n.guard = 1'b0;
            n.phase = (s.phase + 1) % PHASES;
        end else if (s.gr >= 0) begin
            n.held = s.held + 1;
            if (l[s.gr] || !r[s.gr]) begin
                n.gr = -1;
                n.guard = 1'b1;
            end else if (n.held == SLOT_MAX) begin
                n.gr = -1;
                n.guard = 1'b1;
                n.to = 1'b1;
            end
        end else if (e) begin
            if (inject) begin
                n.phase = 0;
            end else if (r[s.phase % NREQ]) begin
                n.gr = s.phase % NREQ;
                n.held = 0;
            end else begin
                n.phase = (s.phase + 1) % PHASES;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m <= '{phase: 0, gr: -1, held: 0, guard: 1'b0, to: 1'b0};
        end else begin
            m <= modelStep(m, en, req, rel, inj);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareAll();
        checkOutput("gnt", 32'(gnt), (m.gr >= 0) ? (32'd1 << m.gr) : 32'd0);
        checkOutput("busy", 32'(busy), 32'(m.gr >= 0));
        checkOutput("timeout", 32'(timeout), 32'(m.to));
        checkOutput("jc_state", 32'(jc_state), 32'(JC_SEQ[m.phase]));
        checkOutput("phase", 32'(phase), 32'(m.phase));
        if (m.gr >= 0) begin
            checkOutput("gnt_id", 32'(gnt_id), 32'(m.gr));
        end
        if (lit_valid) begin
            checkOutput("lit_gnt", 32'(gnt), 32'(lit_gnt));
            checkOutput("lit_jc", 32'(jc_state), 32'(lit_jc));
            checkOutput("lit_phase", 32'(phase), 32'(lit_phase));
            checkOutput("lit_busy", 32'(busy), 32'(lit_busy));
            checkOutput("lit_timeout", 32'(timeout), 32'(lit_to));
        end
    endtask

    // Registered outputs are sampled on the falling edge; an async reset
    // asserted while clk is high is sampled 1ns later.
    initial begin
        forever begin
            @(negedge clk or negedge rstn);
            if (clk) #1;
            if (cmp_on) compareAll();
        end
    end

    task automatic applyStimulus(input logic e, input logic [3:0] r, input logic [3:0] l);
        @(negedge clk);
        #1;
        en = e;
        req = r;
        rel = l;
        inj = 1'b0;
        lit_valid = 1'b0;
    endtask

    task automatic setExpect(input logic [3:0] g, input logic [3:0] j, input int p, input logic b, input logic t);
        lit_gnt = g;
        lit_jc = j;
        lit_phase = p;
        lit_busy = b;
        lit_to = t;
        lit_valid = 1'b1;
    endtask

    task automatic doReset(input logic e, input logic [3:0] r);
        applyStimulus(e, r, 4'b0000);
        rstn = 1'b0;
        applyStimulus(e, r, 4'b0000);
        applyStimulus(e, r, 4'b0000);
        rstn = 1'b1;
    endtask

    task automatic scenarioFirstGrant();
        doReset(1'b1, 4'b0100);
        setExpect(4'b0000, 4'b0001, 1, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b0100, 4'b0000);
        setExpect(4'b0000, 4'b0011, 2, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b0100, 4'b0000);
        setExpect(4'b0100, 4'b0011, 2, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'b0100, 4'b0000);
    endtask

    initial begin
        rstn = 1'b0;
        en = 1'b0;
        req = 4'b0000;
        rel = 4'b0000;
        applyStimulus(1'b0, 4'b0000, 4'b0000);
        cmp_on = 1'b1;

        $display("[TB] first grant after reset");
        scenarioFirstGrant();

        $display("[TB] round robin with release on 2nd busy cycle");
        doReset(1'b1, 4'b1111);
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b1, 4'b1111, (i % 4 == 2) ? 4'b1111 : 4'b0000);
            if (i + 1 == 21) setExpect(4'b0010, 4'b1110, 5, 1'b1, 1'b0);
            if (i + 1 == 29) setExpect(4'b1000, 4'b1000, 7, 1'b1, 1'b0);
            if (i + 1 == 32) setExpect(4'b0000, 4'b0000, 0, 1'b0, 1'b0);
        end

        $display("[TB] slot timeout");
        doReset(1'b1, 4'b0010);
        for (int i = 1; i < 11; i++) begin
            applyStimulus(1'b1, 4'b0010, 4'b0000);
            if (i + 1 == 9)  setExpect(4'b0010, 4'b0001, 1, 1'b1, 1'b0);
            if (i + 1 == 10) setExpect(4'b0000, 4'b0001, 1, 1'b0, 1'b1);
            if (i + 1 == 11) setExpect(4'b0000, 4'b0011, 2, 1'b0, 1'b0);
        end

        $display("[TB] enable low in idle and busy");
        doReset(1'b0, 4'b1111);
        setExpect(4'b0000, 4'b0000, 0, 1'b0, 1'b0);
        for (int i = 1; i < 10; i++) begin
            applyStimulus(1'b0, 4'b1111, 4'b0000);
            setExpect(4'b0000, 4'b0000, 0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 4'b1111, 4'b0000);
        for (int i = 11; i < 18; i++) begin
            applyStimulus(1'b0, 4'b1111, (i + 1 == 15) ? 4'b0001 : 4'b0000);
            if (i + 1 == 14) setExpect(4'b0001, 4'b0000, 0, 1'b1, 1'b0);
            if (i + 1 == 16) setExpect(4'b0000, 4'b0001, 1, 1'b0, 1'b0);
            if (i + 1 == 18) setExpect(4'b0000, 4'b0001, 1, 1'b0, 1'b0);
        end

        $display("[TB] illegal ring pattern recovery");
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        inj = 1'b1;
        force dut.u_core.jc = 4'b0101;
        #1;
        release dut.u_core.jc;
        setExpect(4'b0000, 4'b0000, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b0000);

        $display("[TB] async reset during grant");
        doReset(1'b1, 4'b1111);
        applyStimulus(1'b1, 4'b1111, 4'b0000);
        @(posedge clk);
        #2;
        setExpect(4'b0000, 4'b0000, 0, 1'b0, 1'b0);
        rstn = 1'b0;
        scenarioFirstGrant();

        $display("[TB] random traffic");
        rnd_req = 4'b1111;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) rnd_req = 4'($urandom);
            applyStimulus($urandom_range(0, 7) != 0, rnd_req,
                          ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000);
        end

        applyStimulus(1'b0, 4'b0000, 4'b0000);
        @(negedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
